imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the instruction memory. Accepts a byte stream (header, instruction words, optional checksum) over a valid/ready handshake and turns it into word writes on the instruction memory write port. Holds the processor core in reset until the image is fully loaded. Sits between the host byte link (UART receiver or testbench driver) and the instruction memory write side.

## Interface
- WIDTH, 32, instruction word width in bits; must be a multiple of 8. BPW = WIDTH/8 bytes per word.
- DEPTH, 64, instruction memory depth in words; must be ≤ 255.
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  byte on in_data is valid
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte this cycle
- we  out  1  instruction memory write enable, one-cycle pulse per word
- waddr  out  WIDTH  byte address of the word being written (word-aligned, index<<2)
- wdata  out  WIDTH  assembled instruction word
- cpu_hold  out  1  holds the core in reset while high
- done  out  1  image loaded successfully (sticky)
- err  out  1  load aborted (sticky)

## Operation
- A byte transfers when in_valid && in_ready on a rising edge.
- Stream format: header byte N (word count), then N words of BPW bytes each, least-significant byte first. With IMEM_LOADER_CHECKSUM_EN, one trailer byte follows.
- States: HDR, DATA, WRITE, CHK (only with macro), DONE, ERR.
- HDR: in_ready=1. On accept: N=0 → DONE (or CHK with macro); N>DEPTH → ERR; otherwise store N, clear word index and byte counter → DATA.
- DATA: in_ready=1. Each accepted byte is shifted into the word buffer at bit position 8·byte_cnt. After byte BPW-1 is accepted → WRITE.
- WRITE: in_ready=0. we=1 for exactly this cycle; waddr = index<<2 (zero-extended); wdata = assembled word. Then index increments; if the new index == N → DONE (or CHK), else → DATA with byte_cnt=0.
- CHK: in_ready=1. Accepted byte is compared with the running XOR of all data bytes. Match → DONE; mismatch → ERR.
- DONE: in_ready=0, cpu_hold=0, done=1. Further bytes are not accepted. Exit only via rst.
- ERR: in_ready=0, cpu_hold=1, err=1. Exit only via rst.
- in_data is ignored when in_valid=0. Bubbles between bytes of any length are legal.

## Timing
- Reset values: state=HDR, in_ready=1 (the first cycle after rst deasserts), we=0, waddr=0, wdata=0, cpu_hold=1, done=0, err=0. Index, byte_cnt and XOR accumulator are 0.
- Latency: the write pulse occurs in the cycle after the last byte of a word is accepted. A back-to-back stream sustains 1 word per BPW+1 cycles.
- The transition to DONE takes effect the cycle after the final WRITE (or CHK accept). cpu_hold falls and done rises together in that cycle.
- waddr and wdata stay stable after WRITE until the next WRITE. They are valid only while we=1.
- rst asserted mid-load: the next state is HDR and any partial word is discarded. Memory words already written are not cleared. cpu_hold returns to 1.
- rst has priority over a simultaneous byte accept.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - CHK state and XOR accumulator are built.
  - One trailer byte equal to the XOR of all N·BPW data bytes is required.
  - A mismatch ends in ERR with cpu_hold kept high.
  - For N=0 the expected trailer is 0x00.
- Not defined:
  - There is no CHK state or accumulator.
  - The load completes straight after the last WRITE, and no trailer byte is consumed.

## Test plan
- Load 3 words: bytes 03, 13 00 A0 00, B3 80 50 00, B3 01 01 00 (macro off) → we pulses at waddr 0x0, 0x4, 0x8 with wdata 0x00A00013, 0x005080B3, 0x000101B3; done=1 and cpu_hold=0 one cycle after the third pulse.
- Same stream with random 0–5 cycle in_valid gaps → identical write sequence. in_ready must be 0 exactly in WRITE cycles.
- Header 0x41 (65 > DEPTH) → err=1, no we pulse, in_ready=0, cpu_hold stays 1.
- Macro on, 1 word 13 00 00 00 with trailer 0x13 → done=1. The same word with trailer 0x12 → err=1 after a single we pulse.
- rst asserted after 2 bytes of word 1, then a full 1-word reload → exactly one we pulse at waddr 0x0 carrying the new word.
- Header 0x00 (macro off) → done=1 on the next cycle, no we pulse.

Source files
------------

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time writer for the instruction memory. Takes a byte stream made of a
// header byte N (word count), then N little-endian words of WIDTH/8 bytes, and
// issues one memory write per word. The core is held in reset (cpu_hold=1)
// until the whole image has been written.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, a trailer byte equal to the XOR of every data byte must
//   follow the last word; a mismatch ends the load in the error state.
//
// Parameters
//   WIDTH     instruction word width in bits (multiple of 8)
//   DEPTH     instruction memory depth in words (<= 255)
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   in_valid  byte on in_data is valid
//   in_data   stream byte
//   in_ready  loader accepts a byte this cycle
//   we        one-cycle write pulse per assembled word
//   waddr     byte address of the written word (word index << 2)
//   wdata     assembled instruction word
//   cpu_hold  keeps the core in reset while high
//   done      image loaded successfully (sticky until rst)
//   err       load aborted (sticky until rst)
// -----------------------------------------------------------------------------
module imem_loader #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   output logic             we,
   output logic [WIDTH-1:0] waddr,
   output logic [WIDTH-1:0] wdata,
   output logic             cpu_hold,
   output logic             done,
   output logic             err
);

   localparam int BPW   = WIDTH / 8;
   localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BPW - 1);
   localparam logic [7:0]       DEPTH_B   = 8'(DEPTH);

   typedef enum logic [2:0] {
      ST_HDR   = 3'd0,
      ST_DATA  = 3'd1,
      ST_WRITE = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHK   = 3'd3,
`endif
      ST_DONE  = 3'd4,
      ST_ERR   = 3'd5
   } state_t;

   // State entered once the last word has been written (or for an empty image).
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t ST_LAST = ST_CHK;
`else
   localparam state_t ST_LAST = ST_DONE;
`endif

`ifdef IMEM_LOADER_CHECKSUM_EN
   // Running checksum update: XOR of all data bytes.
   function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction
`endif

   state_t             state_r;
   state_t             state_next_s;
   logic [7:0]         count_r;
   logic [7:0]         idx_r;
   logic [7:0]         idx_inc_s;
   logic [CNT_W-1:0]   byte_cnt_r;
   logic [WIDTH-1:0]   wbuf_r;
   logic [WIDTH-1:0]   word_next_s;
   logic               accept_s;
   logic               last_byte_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]         xor_r;
`endif

   logic               ready_r;
   logic               we_r;
   logic [WIDTH-1:0]   waddr_r;
   logic [WIDTH-1:0]   wdata_r;
   logic               hold_r;
   logic               done_r;
   logic               err_r;

   logic               ready_next_s;
   logic               we_next_s;
   logic               hold_next_s;
   logic               done_next_s;
   logic               err_next_s;

   // ready_r always mirrors the current state's acceptance, so it gates the handshake.
   assign accept_s    = in_valid && ready_r;
   assign last_byte_s = (byte_cnt_r == LAST_BYTE);
   assign idx_inc_s   = idx_r + 8'd1;

   assign in_ready = ready_r;
   assign we       = we_r;
   assign waddr    = waddr_r;
   assign wdata    = wdata_r;
   assign cpu_hold = hold_r;
   assign done     = done_r;
   assign err      = err_r;

   // Word buffer with the incoming byte merged at its little-endian lane.
   always_comb begin
      word_next_s = wbuf_r;
      word_next_s[{byte_cnt_r, 3'b000} +: 8] = in_data;
   end

   // Next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_HDR: begin
            if (accept_s) begin
               if (in_data == 8'd0) begin
                  state_next_s = ST_LAST;
               end else if (in_data > DEPTH_B) begin
                  state_next_s = ST_ERR;
               end else begin
                  state_next_s = ST_DATA;
               end
            end else begin
               state_next_s = ST_HDR;
            end
         end
         ST_DATA: begin
            if (accept_s && last_byte_s) begin
               state_next_s = ST_WRITE;
            end else begin
               state_next_s = ST_DATA;
            end
         end
         ST_WRITE: begin
            if (idx_inc_s == count_r) begin
               state_next_s = ST_LAST;
            end else begin
               state_next_s = ST_DATA;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CHK: begin
            if (accept_s) begin
               if (in_data == xor_r) begin
                  state_next_s = ST_DONE;
               end else begin
                  state_next_s = ST_ERR;
               end
            end else begin
               state_next_s = ST_CHK;
            end
         end
`endif
         ST_DONE: state_next_s = ST_DONE;
         ST_ERR:  state_next_s = ST_ERR;
         // An illegal encoding is treated as a failed load.
         default: state_next_s = ST_ERR;
      endcase
   end

   // Output decode of the upcoming state, so outputs come straight from flops.
   always_comb begin
      ready_next_s = 1'b0;
      we_next_s    = 1'b0;
      hold_next_s  = 1'b1;
      done_next_s  = 1'b0;
      err_next_s   = 1'b0;
      case (state_next_s)
         ST_HDR:   ready_next_s = 1'b1;
         ST_DATA:  ready_next_s = 1'b1;
         ST_WRITE: we_next_s    = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CHK:   ready_next_s = 1'b1;
`endif
         ST_DONE: begin
            hold_next_s = 1'b0;
            done_next_s = 1'b1;
         end
         ST_ERR:   err_next_s   = 1'b1;
         default:  err_next_s   = 1'b1;
      endcase
   end

   // State register, registered outputs and load datapath.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_HDR;
         count_r    <= 8'd0;
         idx_r      <= 8'd0;
         byte_cnt_r <= '0;
         wbuf_r     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         xor_r      <= 8'd0;
`endif
         ready_r    <= 1'b1;
         we_r       <= 1'b0;
         waddr_r    <= '0;
         wdata_r    <= '0;
         hold_r     <= 1'b1;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         state_r <= state_next_s;
         ready_r <= ready_next_s;
         we_r    <= we_next_s;
         hold_r  <= hold_next_s;
         done_r  <= done_next_s;
         err_r   <= err_next_s;
         case (state_r)
            ST_HDR: begin
               if (accept_s) begin
                  count_r    <= in_data;
                  idx_r      <= 8'd0;
                  byte_cnt_r <= '0;
                  wbuf_r     <= '0;
               end
            end
            ST_DATA: begin
               if (accept_s) begin
                  wbuf_r <= word_next_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  xor_r  <= chk_update(xor_r, in_data);
`endif
                  if (last_byte_s) begin
                     // Capture address/data now so they hold steady until the next word.
                     byte_cnt_r <= '0;
                     wdata_r    <= word_next_s;
                     waddr_r    <= WIDTH'({idx_r, 2'b00});
                  end else begin
                     byte_cnt_r <= byte_cnt_r + CNT_W'(1);
                  end
               end
            end
            ST_WRITE: begin
               idx_r <= idx_inc_s;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Directed self-checking bench for imem_loader (WIDTH=32, DEPTH=64).
// A negedge monitor logs every write pulse and the first cycle done is seen;
// each scenario then compares the log against hand-computed values.
// -----------------------------------------------------------------------------
module tb_imem_loader;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        we;
   logic [31:0] waddr;
   logic [31:0] wdata;
   logic        cpu_hold;
   logic        done;
   logic        err;

   imem_loader #(.WIDTH(32), .DEPTH(64)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .cpu_hold (cpu_hold),
      .done     (done),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Write log filled by the monitor.
   int          cyc       = 0;
   int          wr_n      = 0;
   int          we_cyc    = -1;
   int          done_cyc  = -1;
   int          ready_bad = 0;
   logic [31:0] wr_addr [8];
   logic [31:0] wr_data [8];

   always @(negedge clk) begin
      cyc++;
      if (we === 1'b1) begin
         if (wr_n < 8) begin
            wr_addr[wr_n] = waddr;
            wr_data[wr_n] = wdata;
         end
         wr_n++;
         we_cyc = cyc;
      end
      if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
      // While loading, in_ready must be low exactly in write cycles.
      if (rst === 1'b0 && done === 1'b0 && err === 1'b0 && in_ready === we) ready_bad++;
   end

   task automatic clear_log();
      wr_n      = 0;
      we_cyc    = -1;
      done_cyc  = -1;
      ready_bad = 0;
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clear_log();
      check_eq({tag, "_rst_ready"}, {31'd0, in_ready}, 32'd1);
      check_eq({tag, "_rst_hold"},  {31'd0, cpu_hold}, 32'd1);
      check_eq({tag, "_rst_flags"}, {29'd0, we, done, err}, 32'd0);
      check_eq({tag, "_rst_waddr"}, waddr, 32'd0);
      check_eq({tag, "_rst_wdata"}, wdata, 32'd0);
   endtask

   // Present one byte after 'gap' idle cycles and hold it until accepted.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      t = 0;
      while (in_ready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) check_eq("send_timeout", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 8'hxx;
   endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam int S3_LEN = 14;
   logic [7:0] stream3 [S3_LEN] = '{8'h03, 8'h13, 8'h00, 8'hA0, 8'h00, 8'hB3, 8'h80,
                                    8'h50, 8'h00, 8'hB3, 8'h01, 8'h01, 8'h00, 8'h63};
`else
   localparam int S3_LEN = 13;
   logic [7:0] stream3 [S3_LEN] = '{8'h03, 8'h13, 8'h00, 8'hA0, 8'h00, 8'hB3, 8'h80,
                                    8'h50, 8'h00, 8'hB3, 8'h01, 8'h01, 8'h00};
`endif

   task automatic load_three(input string tag, input int gapmax);
      for (int i = 0; i < S3_LEN; i++) begin
         send_byte(stream3[i], (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0);
      end
      repeat (3) @(negedge clk);
      check_eq({tag, "_nwr"},   wr_n, 32'd3);
      check_eq({tag, "_a0"},    wr_addr[0], 32'h0000_0000);
      check_eq({tag, "_d0"},    wr_data[0], 32'h00A0_0013);
      check_eq({tag, "_a1"},    wr_addr[1], 32'h0000_0004);
      check_eq({tag, "_d1"},    wr_data[1], 32'h0050_80B3);
      check_eq({tag, "_a2"},    wr_addr[2], 32'h0000_0008);
      check_eq({tag, "_d2"},    wr_data[2], 32'h0001_01B3);
      check_eq({tag, "_done"},  {31'd0, done}, 32'd1);
      check_eq({tag, "_hold"},  {31'd0, cpu_hold}, 32'd0);
      check_eq({tag, "_err"},   {31'd0, err}, 32'd0);
      check_eq({tag, "_ready"}, ready_bad, 32'd0);
`ifndef IMEM_LOADER_CHECKSUM_EN
      check_eq({tag, "_done_lat"}, done_cyc, we_cyc + 1);
`endif
   endtask

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;

      do_reset("init");

      // Back-to-back 3-word image.
      load_three("b2b", 0);

      // Same image with random idle gaps between bytes.
      do_reset("gap");
      load_three("gap", 5);

      // Oversized header.
      do_reset("big");
      send_byte(8'h41, 0);
      @(negedge clk);
      check_eq("big_err",   {31'd0, err}, 32'd1);
      check_eq("big_ready", {31'd0, in_ready}, 32'd0);
      check_eq("big_hold",  {31'd0, cpu_hold}, 32'd1);
      check_eq("big_done",  {31'd0, done}, 32'd0);
      repeat (3) @(negedge clk);
      check_eq("big_nwr",   wr_n, 32'd0);
      check_eq("big_err2",  {31'd0, err}, 32'd1);

`ifndef IMEM_LOADER_CHECKSUM_EN
      // Empty image completes on the next cycle.
      do_reset("zero");
      send_byte(8'h00, 0);
      @(negedge clk);
      check_eq("zero_done", {31'd0, done}, 32'd1);
      check_eq("zero_hold", {31'd0, cpu_hold}, 32'd0);
      check_eq("zero_nwr",  wr_n, 32'd0);
`endif

      // Reset in the middle of a word, then a fresh 1-word load.
      do_reset("mid");
      send_byte(8'h01, 0);
      send_byte(8'h13, 0);
      send_byte(8'h00, 0);
      check_eq("mid_nwr_pre", wr_n, 32'd0);
      do_reset("mid2");
      send_byte(8'h01, 0);
      send_byte(8'hEF, 0);
      send_byte(8'hBE, 0);
      send_byte(8'hAD, 0);
      send_byte(8'hDE, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(8'h22, 0);
`endif
      repeat (2) @(negedge clk);
      check_eq("mid_nwr",  wr_n, 32'd1);
      check_eq("mid_a0",   wr_addr[0], 32'h0000_0000);
      check_eq("mid_d0",   wr_data[0], 32'hDEAD_BEEF);
      check_eq("mid_done", {31'd0, done}, 32'd1);
      check_eq("mid_hold", {31'd0, cpu_hold}, 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Correct trailer.
      do_reset("chk_ok");
      send_byte(8'h01, 0);
      send_byte(8'h13, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h13, 0);
      repeat (2) @(negedge clk);
      check_eq("chk_ok_done", {31'd0, done}, 32'd1);
      check_eq("chk_ok_err",  {31'd0, err}, 32'd0);

      // Wrong trailer.
      do_reset("chk_bad");
      send_byte(8'h01, 0);
      send_byte(8'h13, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h12, 0);
      repeat (2) @(negedge clk);
      check_eq("chk_bad_err",  {31'd0, err}, 32'd1);
      check_eq("chk_bad_hold", {31'd0, cpu_hold}, 32'd1);
      check_eq("chk_bad_nwr",  wr_n, 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
